// File: rtl/adc_seq_pkg.sv
// rtl/adc_seq_pkg.sv - shared types and sizing helpers for the SAR conversion sequencer
package adc_seq_pkg;

    // Sequencer phases for one conversion / one channel
    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        CONVERT,
        ACCUM,
        PUSH
    } seq_state_t;

    // Headroom above RESULT_BITS so 2^7 full-scale conversions can be summed
    localparam int ACC_EXTRA_BITS = 7;

    function automatic int acc_width(input int result_bits);
        return result_bits + ACC_EXTRA_BITS;
    endfunction

    // Index width for 0..n-1, never narrower than one bit
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/adc_result_fifo.sv
// rtl/adc_result_fifo.sv - result buffer, DEPTH-entry FIFO with ADC_SEQ_FIFO_EN, else one register
module adc_result_fifo
    import adc_seq_pkg::*;
#(
    parameter int WIDTH = 14,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s_tdata,
    input  logic             s_tvalid,
    output logic [WIDTH-1:0] m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             overflow
);

    logic pop;
    logic push_ok;

`ifdef ADC_SEQ_FIFO_EN
    localparam int PTR_W = idx_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             full;

    assign full     = (count == (PTR_W + 1)'(DEPTH));
    assign m_tvalid = (count != '0);
    assign pop      = m_tvalid && m_tready;
    // A same-cycle pop frees the slot, so a push into a full buffer is still taken
    assign push_ok  = s_tvalid && (!full || pop);
    assign m_tdata  = m_tvalid ? mem[rd_ptr] : '0;

    // Storage array; pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= s_tdata;
        end
    end

    // Pointers, occupancy and the sticky drop flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop) begin
                count <= count + 1'b1;
            end else if (!push_ok && pop) begin
                count <= count - 1'b1;
            end
            if (s_tvalid && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end
`else
    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             unused_depth;

    assign unused_depth = (DEPTH != 0);
    assign m_tvalid     = valid_q;
    assign pop          = valid_q && m_tready;
    assign push_ok      = s_tvalid && (!valid_q || pop);
    assign m_tdata      = valid_q ? data_q : '0;

    // Single holding register with the same accept/drop rules as the FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q   <= '0;
            valid_q  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                data_q  <= s_tdata;
                valid_q <= 1'b1;
            end else if (pop) begin
                valid_q <= 1'b0;
            end
            if (s_tvalid && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/adc_sar_sequencer.sv
// rtl/adc_sar_sequencer.sv - multi-channel averaging SAR sequencer; buffer depth set by ADC_SEQ_FIFO_EN
module adc_sar_sequencer
    import adc_seq_pkg::*;
#(
    parameter int RESULT_BITS   = 12,
    parameter int NUM_CHANNELS  = 4,
    parameter int SAMPLE_CYCLES = 2,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                                clk_dig_in,
    input  logic                                rst,
    input  logic                                start_in,
    input  logic                                continuous_in,
    input  logic [NUM_CHANNELS-1:0]             channel_mask_in,
    input  logic [2:0]                          avg_log2_in,
    input  logic                                comparator_in,
    output logic                                enable_loop_out,
    output logic                                sample_out,
    output logic                                sample_out_n,
    output logic [idx_width(NUM_CHANNELS)-1:0]  channel_sel_out,
    output logic [RESULT_BITS-1:0]              pswitch_out,
    output logic [RESULT_BITS-1:0]              nswitch_out,
    output logic [RESULT_BITS-1:0]              result_data_out,
    output logic [idx_width(NUM_CHANNELS)-1:0]  result_channel_out,
    output logic                                result_valid_out,
    input  logic                                result_ready_in,
    output logic                                overflow_out,
    output logic                                busy_out
);

    localparam int CH_W   = idx_width(NUM_CHANNELS);
    localparam int ACC_W  = acc_width(RESULT_BITS);
    localparam int BIT_W  = idx_width(RESULT_BITS);
    localparam int SAMP_W = idx_width(SAMPLE_CYCLES);

    seq_state_t state;
    seq_state_t state_nxt;

    logic [NUM_CHANNELS-1:0] mask_q;
    logic [2:0]              avg_q;
    logic [CH_W-1:0]         chan_q;
    logic [SAMP_W-1:0]       samp_cnt;
    logic [BIT_W-1:0]        bit_idx;
    logic [RESULT_BITS-1:0]  sar_word;
    logic [RESULT_BITS-1:0]  trial;
    logic [ACC_W-1:0]        acc;
    logic [7:0]              conv_cnt;

    logic [CH_W-1:0]         first_ch;
    logic [CH_W-1:0]         next_ch;
    logic                    has_next;
    logic                    start_ok;
    logic                    wrap_ok;
    logic                    sample_done;
    logic                    conv_last;
    logic [RESULT_BITS-1:0]  avg_result;

    assign start_ok    = start_in && (channel_mask_in != '0);
    // A continuous wrap re-reads the live mask; an empty mask ends the scan
    assign wrap_ok     = continuous_in && (channel_mask_in != '0);
    assign sample_done = (samp_cnt == SAMP_W'(SAMPLE_CYCLES - 1));
    assign trial       = sar_word | (RESULT_BITS'(1) << bit_idx);
    assign conv_last   = ({1'b0, conv_cnt} + 9'd1) >= (9'd1 << avg_q);
    assign avg_result  = RESULT_BITS'(acc >> avg_q);

    // Lowest requested channel in the live mask, used at scan (re)start
    always_comb begin
        first_ch = '0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (channel_mask_in[i]) begin
                first_ch = CH_W'(i);
            end
        end
    end

    // Next channel above the current one in the latched mask
    always_comb begin
        next_ch  = '0;
        has_next = 1'b0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (mask_q[i] && (CH_W'(i) > chan_q)) begin
                next_ch  = CH_W'(i);
                has_next = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk_dig_in) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = SAMPLE;
            SAMPLE:  if (sample_done) state_nxt = CONVERT;
            CONVERT: if (bit_idx == '0) state_nxt = ACCUM;
            ACCUM:   state_nxt = conv_last ? PUSH : SAMPLE;
            PUSH:    state_nxt = (has_next || wrap_ok) ? SAMPLE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Analog-facing outputs are pure functions of state
    always_comb begin
        sample_out      = (state == SAMPLE);
        sample_out_n    = !(state == SAMPLE);
        enable_loop_out = (state == CONVERT);
        pswitch_out     = (state == CONVERT) ? trial : '0;
        nswitch_out     = ~((state == CONVERT) ? trial : '0);
        busy_out        = (state != IDLE);
        channel_sel_out = (state != IDLE) ? chan_q : '0;
    end

    // Datapath: configuration latch, sample timer, binary search, accumulation
    always_ff @(posedge clk_dig_in) begin
        if (rst) begin
            mask_q   <= '0;
            avg_q    <= '0;
            chan_q   <= '0;
            samp_cnt <= '0;
            bit_idx  <= '0;
            sar_word <= '0;
            acc      <= '0;
            conv_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    acc      <= '0;
                    conv_cnt <= '0;
                    samp_cnt <= '0;
                    if (start_ok) begin
                        mask_q <= channel_mask_in;
                        avg_q  <= avg_log2_in;
                        chan_q <= first_ch;
                    end
                end
                SAMPLE: begin
                    samp_cnt <= samp_cnt + 1'b1;
                    sar_word <= '0;
                    bit_idx  <= BIT_W'(RESULT_BITS - 1);
                end
                CONVERT: begin
                    if (comparator_in) begin
                        sar_word <= trial;
                    end
                    bit_idx <= bit_idx - 1'b1;
                end
                ACCUM: begin
                    acc      <= acc + ACC_W'(sar_word);
                    conv_cnt <= conv_cnt + 8'd1;
                    samp_cnt <= '0;
                end
                PUSH: begin
                    acc      <= '0;
                    conv_cnt <= '0;
                    samp_cnt <= '0;
                    if (has_next) begin
                        chan_q <= next_ch;
                    end else if (wrap_ok) begin
                        mask_q <= channel_mask_in;
                        avg_q  <= avg_log2_in;
                        chan_q <= first_ch;
                    end
                end
                default: ;
            endcase
        end
    end

    adc_result_fifo #(
        .WIDTH (RESULT_BITS + CH_W),
        .DEPTH (FIFO_DEPTH)
    ) u_result_fifo (
        .clk      (clk_dig_in),
        .rst      (rst),
        .s_tdata  ({chan_q, avg_result}),
        .s_tvalid (state == PUSH),
        .m_tdata  ({result_channel_out, result_data_out}),
        .m_tvalid (result_valid_out),
        .m_tready (result_ready_in),
        .overflow (overflow_out)
    );

endmodule

// File: tb/tb_adc_sar_sequencer.sv
// tb/tb_adc_sar_sequencer.sv - self-checking bench for adc_sar_sequencer with a cycle-level scan model
module tb_adc_sar_sequencer;

    localparam int RB = 12;
    localparam int NC = 4;
    localparam int SC = 2;
    localparam int CW = 2;
`ifdef ADC_SEQ_FIFO_EN
    localparam int D = 4;
`else
    localparam int D = 1;
`endif

    typedef struct packed {
        logic [CW-1:0] ch;
        logic [RB-1:0] data;
    } res_t;

    logic          clk_dig_in;
    logic          rst;
    logic          start_in;
    logic          continuous_in;
    logic [NC-1:0] channel_mask_in;
    logic [2:0]    avg_log2_in;
    logic          comparator_in;
    logic          enable_loop_out;
    logic          sample_out;
    logic          sample_out_n;
    logic [CW-1:0] channel_sel_out;
    logic [RB-1:0] pswitch_out;
    logic [RB-1:0] nswitch_out;
    logic [RB-1:0] result_data_out;
    logic [CW-1:0] result_channel_out;
    logic          result_valid_out;
    logic          result_ready_in;
    logic          overflow_out;
    logic          busy_out;

    logic [RB-1:0] cur_code;
    res_t          model_q[$];
    bit            model_ovf;
    int            code_q[$];
    int            n_checks;
    int            n_fail;
    int            cyc;
    int            start_cyc;
    int            first_valid;
    int            sample_rises;
    bit            prev_sample;
    int            ready_mode;

    adc_sar_sequencer #(
        .RESULT_BITS   (RB),
        .NUM_CHANNELS  (NC),
        .SAMPLE_CYCLES (SC),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk_dig_in         (clk_dig_in),
        .rst                (rst),
        .start_in           (start_in),
        .continuous_in      (continuous_in),
        .channel_mask_in    (channel_mask_in),
        .avg_log2_in        (avg_log2_in),
        .comparator_in      (comparator_in),
        .enable_loop_out    (enable_loop_out),
        .sample_out         (sample_out),
        .sample_out_n       (sample_out_n),
        .channel_sel_out    (channel_sel_out),
        .pswitch_out        (pswitch_out),
        .nswitch_out        (nswitch_out),
        .result_data_out    (result_data_out),
        .result_channel_out (result_channel_out),
        .result_valid_out   (result_valid_out),
        .result_ready_in    (result_ready_in),
        .overflow_out       (overflow_out),
        .busy_out           (busy_out)
    );

    // Ideal comparator: input at or above the trial level keeps the bit
    assign comparator_in = (pswitch_out <= cur_code);

    initial clk_dig_in = 1'b0;
    always #5 clk_dig_in = ~clk_dig_in;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] st_pack(bit s, bit en, bit b, logic [CW-1:0] ch, logic [RB-1:0] p);
        return 32'({s, ~s, en, b, ch, p, ~p});
    endfunction

    // Trial word in bit cycle k: code bits above k already resolved, bit k set, below clear
    function automatic logic [RB-1:0] trial_word(int code, int k);
        int hi;
        hi = (code >> (k + 1)) << (k + 1);
        return RB'(hi | (1 << k));
    endfunction

    task automatic chk_state(input string tag, input bit s, input bit en, input bit b,
                             input logic [CW-1:0] ch, input logic [RB-1:0] p);
        check_eq(tag, 32'({sample_out, sample_out_n, enable_loop_out, busy_out,
                           channel_sel_out, pswitch_out, nswitch_out}),
                 st_pack(s, en, b, ch, p));
    endtask

    // One clock: check buffer outputs against the model, then apply pop/push at the edge
    task automatic tick(input bit push_now, input logic [RB-1:0] pdata, input logic [CW-1:0] pch);
        bit   pop;
        res_t r;
        case (ready_mode)
            0:       result_ready_in = 1'b0;
            1:       result_ready_in = 1'b1;
            2:       result_ready_in = 1'($urandom_range(0, 1));
            default: result_ready_in = push_now;
        endcase
        check_eq("valid", 32'(result_valid_out), 32'(model_q.size() != 0));
        if (model_q.size() != 0)
            check_eq("result", 32'({result_channel_out, result_data_out}), 32'(model_q[0]));
        check_eq("overflow", 32'(overflow_out), 32'(model_ovf));
        pop = (model_q.size() != 0) && result_ready_in;
        if (result_valid_out && first_valid < 0) first_valid = cyc;
        if (sample_out && !prev_sample) sample_rises++;
        prev_sample = sample_out;
        @(posedge clk_dig_in);
        if (pop) void'(model_q.pop_front());
        if (push_now) begin
            r.ch   = pch;
            r.data = pdata;
            if (model_q.size() < D) model_q.push_back(r);
            else model_ovf = 1'b1;
        end
        @(negedge clk_dig_in);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            chk_state("idle", 0, 0, 0, '0, '0);
            tick(0, '0, '0);
        end
    endtask

    task automatic chk_reset_values();
        chk_state("rst_state", 0, 0, 0, '0, '0);
        check_eq("rst_result", 32'({result_valid_out, overflow_out, result_channel_out, result_data_out}), 32'd0);
    endtask

    // Walks a scan as nested loops of channels / conversions / phases; abort_k >= 0
    // asserts rst during that bit cycle of the first conversion
    task automatic run_scan(input logic [NC-1:0] mask, input int avg, input int nscans, input int abort_k);
        int code;
        int sum;
        channel_mask_in = mask;
        avg_log2_in     = 3'(avg);
        continuous_in   = (nscans > 1);
        start_in        = 1'b1;
        start_cyc       = cyc;
        first_valid     = -1;
        sample_rises    = 0;
        chk_state("start_idle", 0, 0, 0, '0, '0);
        tick(0, '0, '0);
        start_in = 1'b0;
        for (int sc = 0; sc < nscans; sc++) begin
            continuous_in = (sc < nscans - 1);
            for (int ch = 0; ch < NC; ch++) begin
                if (mask[ch]) begin
                    sum = 0;
                    for (int j = 0; j < (1 << avg); j++) begin
                        code = (code_q.size() != 0) ? code_q.pop_front() : int'($urandom_range(0, 4095));
                        cur_code = RB'(code);
                        for (int s = 0; s < SC; s++) begin
                            chk_state("sample", 1, 0, 1, CW'(ch), '0);
                            tick(0, '0, '0);
                        end
                        for (int k = RB - 1; k >= 0; k--) begin
                            chk_state("convert", 0, 1, 1, CW'(ch), trial_word(code, k));
                            if (k == abort_k) begin
                                rst = 1'b1;
                                @(posedge clk_dig_in);
                                @(negedge clk_dig_in);
                                cyc++;
                                chk_reset_values();
                                rst = 1'b0;
                                model_q.delete();
                                model_ovf   = 1'b0;
                                prev_sample = 1'b0;
                                return;
                            end
                            tick(0, '0, '0);
                        end
                        chk_state("accum", 0, 0, 1, CW'(ch), '0);
                        tick(0, '0, '0);
                        sum += code;
                    end
                    chk_state("push", 0, 0, 1, CW'(ch), '0);
                    tick(1, RB'(sum >> avg), CW'(ch));
                end
            end
        end
        chk_state("end_idle", 0, 0, 0, '0, '0);
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        cyc = 0;
        model_ovf = 1'b0;
        prev_sample = 1'b0;
        ready_mode = 1;
        rst = 1'b1;
        start_in = 1'b0;
        continuous_in = 1'b0;
        channel_mask_in = '0;
        avg_log2_in = '0;
        result_ready_in = 1'b0;
        cur_code = '0;
        repeat (3) @(posedge clk_dig_in);
        @(negedge clk_dig_in);
        chk_reset_values();
        rst = 1'b0;
        idle(2);

        // single channel, single conversion, fixed code; also result latency
        ready_mode = 1;
        code_q = '{32'hA5C};
        run_scan(4'b0001, 0, 1, -1);
        idle(3);
        check_eq("latency", 32'(first_valid - start_cyc), 32'(SC + RB + 3));

        // averaging of four known codes
        code_q = '{100, 101, 102, 103};
        run_scan(4'b0001, 2, 1, -1);
        idle(3);
        check_eq("sample_pulses", 32'(sample_rises), 32'd4);

        // sparse mask, one-shot scan
        run_scan(4'b1010, 0, 1, -1);
        idle(3);

        // empty mask: start must be ignored
        channel_mask_in = '0;
        start_in = 1'b1;
        chk_state("mask0_idle", 0, 0, 0, '0, '0);
        tick(0, '0, '0);
        start_in = 1'b0;
        idle(4);

        // consumer stalled in continuous mode: fill, then drop
        ready_mode = 0;
        run_scan(4'b0001, 0, 5, -1);
        check_eq("ovf_after_fill", 32'(overflow_out), 32'd1);
        ready_mode = 1;
        idle(D + 2);

        // reset mid-conversion with a held result, then a clean conversion
        ready_mode = 0;
        run_scan(4'b0001, 0, 1, -1);
        run_scan(4'b0011, 0, 1, 5);
        idle(2);
        ready_mode = 1;
        run_scan(4'b0100, 1, 1, -1);
        idle(3);

        // full buffer with pop and push in the same cycle
        ready_mode = 0;
        run_scan(4'b0001, 0, D, -1);
        ready_mode = 3;
        run_scan(4'b0001, 0, 1, -1);
        check_eq("ovf_pushpop", 32'(overflow_out), 32'd0);
        ready_mode = 1;
        idle(D + 2);

        // randomized scans with random consumer back-pressure
        for (int t = 0; t < 8; t++) begin
            ready_mode = 2;
            run_scan(NC'($urandom_range(1, 15)), int'($urandom_range(0, 2)), int'($urandom_range(1, 2)), -1);
            ready_mode = 1;
            idle(D + 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
